// File: rtl/fpu_pkg.sv
// ============================================================================
// Module      : fpu_pkg
// Description : Shared FPU datapath types: round modes, normalized result
//               record, fflags layout and binary32 magnitude constants.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package fpu_pkg;

    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } fpu_round_mode_t;

    typedef struct packed {
        logic            valid;
        logic            sign;
        logic [7:0]      exponent;
        logic [23:0]     mantissa;
        logic [2:0]      guard;
        logic            nan;
        logic            inf;
        logic            zero;
        fpu_round_mode_t mode;
    } fpu_result_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fpu_fflags_t;

    localparam logic [30:0] MAX_FINITE_MAG = 31'h7F7F_FFFF;
    localparam logic [30:0] c_INF_MAG      = 31'h7F80_0000;

endpackage

`default_nettype wire

// File: rtl/fpu_round_compute.sv
// ============================================================================
// Module      : fpu_round_compute
// Description : Combinational round-increment decision for binary32 results.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_round_compute
    import fpu_pkg::*;
(
    input  logic            i_sign,
    input  logic            i_lsb,
    input  logic [2:0]      i_guard,
    input  fpu_round_mode_t i_mode,
    output logic            o_inc,
    output logic            o_inexact
);

    always_comb begin
        o_inexact = |i_guard;
        case (i_mode)
            RM_RTZ:  o_inc = 1'b0;
            RM_RDN:  o_inc = o_inexact & i_sign;
            RM_RUP:  o_inc = o_inexact & ~i_sign;
            RM_RMM:  o_inc = i_guard[2];
            // RNE, and any unassigned mode code falls back to RNE
            default: o_inc = i_guard[2] & (i_guard[1] | i_guard[0] | i_lsb);
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/fpu_round_stage.sv
// ============================================================================
// Module      : fpu_round_stage
// Description : Two-stage binary32 rounding, special-case resolution, packing
//               and fflags generation with a valid/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module fpu_round_stage
    import fpu_pkg::*;
#(
    parameter logic [31:0] CANONICAL_NAN = 32'h7FC0_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  fpu_result_t in_result,
    input  logic        in_invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_flags
);

    logic            w_s1_adv;
    logic            w_s2_adv;
    logic            w_inc;
    logic            w_inexact;
    logic            w_unused;

    logic            r_s1_valid;
    logic            r_s1_sign;
    logic [7:0]      r_s1_exp;
    logic [22:0]     r_s1_mant;
    logic            r_s1_inc;
    logic            r_s1_inexact;
    logic            r_s1_tiny;
    logic            r_s1_nan;
    logic            r_s1_inf;
    logic            r_s1_zero;
    fpu_round_mode_t r_s1_mode;
    logic            r_s1_invalid;

    logic [30:0]     w_mag;
    logic            w_ovf;
    logic            w_ovf_to_max;
    logic [31:0]     w_result;
    fpu_fflags_t     w_flags;

    // Hidden bit is implied by the exponent; the struct valid bit is redundant.
    assign w_unused = ^{in_result.valid, in_result.mantissa[23]};

    assign w_s2_adv = !out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    fpu_round_compute u_round_compute (
        .i_sign    (in_result.sign),
        .i_lsb     (in_result.mantissa[0]),
        .i_guard   (in_result.guard),
        .i_mode    (in_result.mode),
        .o_inc     (w_inc),
        .o_inexact (w_inexact)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_exp     <= 8'h00;
            r_s1_mant    <= 23'h0;
            r_s1_inc     <= 1'b0;
            r_s1_inexact <= 1'b0;
            r_s1_tiny    <= 1'b0;
            r_s1_nan     <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_zero    <= 1'b0;
            r_s1_mode    <= RM_RNE;
            r_s1_invalid <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid   <= in_valid;
            r_s1_sign    <= in_result.sign;
            r_s1_exp     <= in_result.exponent;
            r_s1_mant    <= in_result.mantissa[22:0];
            r_s1_inc     <= w_inc;
            r_s1_inexact <= w_inexact;
            r_s1_tiny    <= (in_result.exponent == 8'h00);
            r_s1_nan     <= in_result.nan;
            r_s1_inf     <= in_result.inf;
            r_s1_zero    <= in_result.zero;
            r_s1_mode    <= in_result.mode;
            r_s1_invalid <= in_invalid;
        end
    end

    // The carry out of the mantissa field lands in the exponent field.
    assign w_mag        = {r_s1_exp, r_s1_mant} + {30'd0, r_s1_inc};
    assign w_ovf        = (w_mag[30:23] == 8'hFF) || (r_s1_exp == 8'hFF);
    assign w_ovf_to_max = (r_s1_mode == RM_RTZ)
                       || ((r_s1_mode == RM_RDN) && !r_s1_sign)
                       || ((r_s1_mode == RM_RUP) &&  r_s1_sign);

    always_comb begin
        w_result   = {r_s1_sign, w_mag};
        w_flags    = '0;
        w_flags.nv = r_s1_invalid;
        if (r_s1_nan) begin
            w_result = CANONICAL_NAN;
        end else if (r_s1_inf) begin
            w_result = {r_s1_sign, c_INF_MAG};
        end else if (r_s1_zero) begin
            w_result = {r_s1_sign, 31'h0};
            w_flags  = '0;
        end else if (w_ovf) begin
            w_result   = {r_s1_sign, w_ovf_to_max ? MAX_FINITE_MAG : c_INF_MAG};
            w_flags.of = 1'b1;
            w_flags.nx = 1'b1;
        end else begin
            w_flags.uf = r_s1_tiny & r_s1_inexact;
            w_flags.nx = r_s1_inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= 32'h0;
            out_flags  <= 5'h0;
        end else if (w_s2_adv) begin
            out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                out_result <= w_result;
                out_flags  <= w_flags;
            end
        end
    end

endmodule

`default_nettype wire
